// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: multi-lane RV32I immediate decoder with a 2-entry output FIFO.
//   Each lane classifies its instruction format (R/I/S/B/U/J/illegal) and builds the
//   sign-extended XLEN immediate. The decoded bundle is written into a 2-entry FIFO
//   that feeds rename.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   flush                   synchronous drop of buffered bundles and the input bundle
//   in_valid/in_ready       input bundle handshake (in_ready is registered-state only)
//   in_instr, in_lane_vld   lane i instruction at [32*i +: 32], per-lane valid mask
//   out_valid/out_ready     head bundle handshake
//   out_imm, out_type       lane i at [XLEN*i +: XLEN] / [3*i +: 3]
//   out_lane_vld            lane mask carried with the bundle
//   out_illegal             lane valid and opcode unrecognised

// Per-lane decoder: purely combinational.
module imm_lane #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic            vld,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      typ,
  output logic            illegal
);
  typedef enum logic [2:0] {
    T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
    T_U = 3'd4, T_J = 3'd5, T_ILL = 3'd7
  } fmt_e;

  logic signed [31:0] imm32;

  always_comb begin
    imm32   = '0;
    typ     = T_R;
    illegal = 1'b0;
    // Invalid lanes decode to all-zero regardless of the instruction bits.
    if (vld) begin
      case (instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
          imm32 = {{20{instr[31]}}, instr[31:20]};
          typ   = T_I;
        end
        7'b0100011: begin
          imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
          typ   = T_S;
        end
        7'b1100011: begin
          imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
          typ   = T_B;
        end
        7'b0110111, 7'b0010111: begin
          imm32 = {instr[31:12], 12'b0};
          typ   = T_U;
        end
        7'b1101111: begin
          imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
          typ   = T_J;
        end
        7'b0110011: typ = T_R;
        default: begin
          typ     = T_ILL;
          illegal = 1'b1;
        end
      endcase
    end
  end

  // Signed cast fills bits XLEN-1..32 with the sign when XLEN=64.
  assign imm = XLEN'(imm32);
endmodule

module imm_decode_pipe #(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_instr,
  input  logic [LANES-1:0]      in_lane_vld,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN*LANES-1:0] out_imm,
  output logic [3*LANES-1:0]    out_type,
  output logic [LANES-1:0]      out_lane_vld,
  output logic [LANES-1:0]      out_illegal
);
  typedef struct packed {
    logic [LANES-1:0][XLEN-1:0] imm;
    logic [LANES-1:0][2:0]      typ;
    logic [LANES-1:0]           lv;
    logic [LANES-1:0]           ill;
  } bundle_t;

  logic [LANES-1:0][XLEN-1:0] dec_imm;
  logic [LANES-1:0][2:0]      dec_typ;
  logic [LANES-1:0]           dec_ill;
  bundle_t                    din;
  bundle_t [1:0]              mem;
  logic                       wptr, rptr;
  logic [1:0]                 count;
  logic                       push, pop;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    imm_lane #(.XLEN(XLEN)) u_lane (
      .instr   (in_instr[32*i +: 32]),
      .vld     (in_lane_vld[i]),
      .imm     (dec_imm[i]),
      .typ     (dec_typ[i]),
      .illegal (dec_ill[i])
    );
  end

  assign din = '{imm: dec_imm, typ: dec_typ, lv: in_lane_vld, ill: dec_ill};

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem   <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      // Entries are left as-is; only the occupancy state is cleared.
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign out_imm      = mem[rptr].imm;
  assign out_type     = mem[rptr].typ;
  assign out_lane_vld = mem[rptr].lv;
  assign out_illegal  = mem[rptr].ill;
endmodule

// File: tb/tb_imm_decode_pipe.sv
module tb_imm_decode_pipe;
  localparam int LANES = 2;
  localparam int XLEN  = 32;

  logic                  clk = 1'b0;
  logic                  reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [32*LANES-1:0]   in_instr;
  logic [LANES-1:0]      in_lane_vld, out_lane_vld, out_illegal;
  logic [XLEN*LANES-1:0] out_imm;
  logic [3*LANES-1:0]    out_type;

  imm_decode_pipe #(.LANES(LANES), .XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_lane_vld(in_lane_vld),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_type(out_type),
    .out_lane_vld(out_lane_vld), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] i0, i1;
    logic [1:0]  vld;
    logic [63:0] imm;   // {lane1, lane0}
    logic [5:0]  typ;   // {lane1, lane0}
    logic [1:0]  ill;
  } vec_t;

  vec_t tbl [8];
  vec_t q [$];
  int   cur_idx = 0;
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic [31:0] i0, logic [31:0] i1, logic [1:0] vld,
                              logic [31:0] m0, logic [31:0] m1, logic [2:0] t0,
                              logic [2:0] t1, logic [1:0] ill);
    vec_t v;
    v.i0 = i0; v.i1 = i1; v.vld = vld;
    v.imm = {m1, m0}; v.typ = {t1, t0}; v.ill = ill;
    return v;
  endfunction

  // Scoreboard: occupancy/handshake checks, head compare, then queue update.
  always @(negedge clk) begin
    if (!reset_n) q.delete();
    else begin
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() != 2));
      if (out_valid && q.size() != 0) begin
        chk("out_imm", 64'(out_imm), q[0].imm);
        chk("out_type", 64'(out_type), 64'(q[0].typ));
        chk("out_lane_vld", 64'(out_lane_vld), 64'(q[0].vld));
        chk("out_illegal", 64'(out_illegal), 64'(q[0].ill));
      end
      if (flush) q.delete();
      else begin
        if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
        if (in_valid && in_ready) q.push_back(tbl[cur_idx]);
      end
    end
  end

  task automatic drive(int idx);
    cur_idx     = idx;
    in_instr    = {tbl[idx].i1, tbl[idx].i0};
    in_lane_vld = tbl[idx].vld;
    in_valid    = 1'b1;
  endtask

  // Drive a bundle and hold it until accepted; leaves in_valid high.
  task automatic send(int idx);
    bit acc;
    drive(idx);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk); #1;
      if (acc) return;
    end
    chk("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_ready"}, 64'(in_ready), 64'd1);
    chk({nm, "_imm"}, 64'(out_imm), 64'd0);
    chk({nm, "_type"}, 64'(out_type), 64'd0);
    chk({nm, "_lv"}, 64'(out_lane_vld), 64'd0);
    chk({nm, "_ill"}, 64'(out_illegal), 64'd0);
  endtask

  initial begin
    tbl[0] = mk(32'hFFF00093, 32'h00001037, 2'b11, 32'hFFFFFFFF, 32'h00001000, 3'd1, 3'd4, 2'b00);
    tbl[1] = mk(32'hFE000EE3, 32'h0080006F, 2'b11, 32'hFFFFFFFC, 32'h00000008, 3'd3, 3'd5, 2'b00);
    tbl[2] = mk(32'hFE112E23, 32'h0000007F, 2'b11, 32'hFFFFFFFC, 32'h00000000, 3'd2, 3'd7, 2'b10);
    tbl[3] = mk(32'h0000007F, 32'hFE112E23, 2'b10, 32'h00000000, 32'hFFFFFFFC, 3'd0, 3'd2, 2'b00);
    tbl[4] = mk(32'h002081B3, 32'h7FF00013, 2'b11, 32'h00000000, 32'h000007FF, 3'd0, 3'd1, 2'b00);
    tbl[5] = mk(32'h800000EF, 32'h80000063, 2'b11, 32'hFFF00000, 32'hFFFFF000, 3'd5, 3'd3, 2'b00);
    tbl[6] = mk(32'hFFFFF297, 32'h00000003, 2'b01, 32'hFFFFF000, 32'h00000000, 3'd4, 3'd0, 2'b00);
    tbl[7] = mk(32'h00000FE3, 32'h001FF0EF, 2'b11, 32'h0000081E, 32'h000FF800, 3'd3, 3'd5, 2'b00);

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_lane_vld = '0;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Table sweep: every vector streamed once with the consumer always ready.
    for (int k = 0; k < 8; k++) send(k);
    idle();
    drain();

    // Backpressure: A, B fill the FIFO, C is held, then all drain in order.
    out_ready = 1'b0;
    send(0);
    send(1);
    drive(2);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk) chk("full_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(2);
    idle();
    drain();

    // Steady state at count=1: push and pop on the same edge for 10 cycles.
    out_ready = 1'b0;
    send(3);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) send(k % 8);
    idle();
    drain();

    // Flush with a full FIFO and a bundle on the input.
    out_ready = 1'b0;
    send(4);
    send(5);
    drive(6);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    @(negedge clk);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(7);
    idle();
    drain();

    // Reset asserted mid-stream clears outputs immediately.
    out_ready = 1'b0;
    send(1);
    send(5);
    reset_n = 1'b0;
    #1 chk_zero("midreset");
    idle();
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    send(0);
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
